// File: rtl/alu_issue.sv
// Issue front end for the datapath ALU: request handshake -> ALU drive -> captured result handshake.
// Optional macro ALU_ISSUE_CARRY_CHAIN_EN keeps a carry flag so ADC/SBB can chain multi-word arithmetic.
`ifndef NBITS
`define NBITS 8
`endif

module alu_issue #(
    parameter int NBITS = `NBITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [NBITS-1:0] req_a,
    input  logic [NBITS-1:0] req_b,
    output logic [1:0]       alu_f,
    output logic [NBITS-1:0] alu_a,
    output logic [NBITS-1:0] alu_b,
    output logic             alu_c_in,
    input  logic [NBITS-1:0] alu_y,
    input  logic             alu_c_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [NBITS-1:0] res_data,
    output logic             res_carry
);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             capture;
    logic             adc_c_in;
    logic             sbb_c_in;
    logic [1:0]       dec_f;
    logic [NBITS-1:0] dec_b;
    logic             dec_c_in;

    assign accept  = req_valid && req_ready;
    assign capture = (state == EXEC);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = HOLD;
            HOLD:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE) && !rst;
        res_valid = (state == HOLD);
    end

`ifdef ALU_ISSUE_CARRY_CHAIN_EN
    logic carry_flag;

    assign adc_c_in = carry_flag;
    assign sbb_c_in = carry_flag;

    // The flag only moves on arithmetic captures, so it doubles as the reported carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data   <= '0;
            carry_flag <= 1'b0;
        end else if (capture) begin
            res_data <= alu_y;
            if (alu_f == 2'b11) carry_flag <= alu_c_out;
        end
    end

    assign res_carry = carry_flag;
`else
    assign adc_c_in = 1'b0;
    assign sbb_c_in = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_data  <= '0;
            res_carry <= 1'b0;
        end else if (capture) begin
            res_data  <= alu_y;
            res_carry <= (alu_f == 2'b11) && alu_c_out;
        end
    end
`endif

    // Subtraction is A + ~B + c_in; INC is A + 0 + 1.
    always_comb begin
        dec_f    = (req_op < 3'd3) ? req_op[1:0] : 2'b11;
        dec_b    = req_b;
        dec_c_in = 1'b0;
        case (req_op)
            3'd4: dec_c_in = adc_c_in;
            3'd5: begin
                dec_b    = ~req_b;
                dec_c_in = 1'b1;
            end
            3'd6: begin
                dec_b    = ~req_b;
                dec_c_in = sbb_c_in;
            end
            3'd7: begin
                dec_b    = '0;
                dec_c_in = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_f    <= 2'b00;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_c_in <= 1'b0;
        end else if (accept) begin
            alu_f    <= dec_f;
            alu_a    <= req_a;
            alu_b    <= dec_b;
            alu_c_in <= dec_c_in;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed vector table, randomized ops against a reference model,
// back-pressure and mid-operation reset sequences. Follows ALU_ISSUE_CARRY_CHAIN_EN if defined.
`ifndef NBITS
`define NBITS 8
`endif

module tb_alu_issue;

    localparam int N = `NBITS;
`ifdef ALU_ISSUE_CARRY_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [N-1:0] req_a;
    logic [N-1:0] req_b;
    logic [1:0]   alu_f;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic         alu_c_in;
    logic [N-1:0] alu_y;
    logic         alu_c_out;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res_data;
    logic         res_carry;

    int  checks = 0;
    int  failures = 0;
    bit  flag = 1'b0;

    typedef struct {
        logic [2:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [1:0]   f;
        logic [N-1:0] d;
        logic         c;
    } vec_t;

    vec_t vecs[9];

    alu_issue #(.NBITS(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_f(alu_f), .alu_a(alu_a), .alu_b(alu_b), .alu_c_in(alu_c_in),
        .alu_y(alu_y), .alu_c_out(alu_c_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_carry(res_carry)
    );

    always #5 clk = ~clk;

    // Stand-in for the datapath ALU the block drives.
    always_comb begin
        alu_y     = '0;
        alu_c_out = 1'b0;
        case (alu_f)
            2'b00: alu_y = alu_a & alu_b;
            2'b01: alu_y = alu_a | alu_b;
            2'b10: alu_y = ~alu_b;
            default: {alu_c_out, alu_y} = {1'b0, alu_a} + {1'b0, alu_b} + {{N{1'b0}}, alu_c_in};
        endcase
    end

    // Operation semantics in plain integer arithmetic.
    function automatic void refModel(input int op, input int a, input int b, input bit fl,
                                     output int data, output bit carry);
        int mask = (1 << N) - 1;
        int full;
        int borrow;
        data  = 0;
        carry = CHAIN ? fl : 1'b0;
        case (op)
            0: data = a & b;
            1: data = a | b;
            2: data = (~b) & mask;
            3, 4, 7: begin
                if (op == 7)      full = a + 1;
                else if (op == 4) full = a + b + ((CHAIN && fl) ? 1 : 0);
                else              full = a + b;
                data  = full & mask;
                carry = (full > mask);
            end
            default: begin
                borrow = (op == 6 && CHAIN && !fl) ? 1 : 0;
                full   = a - b - borrow;
                data   = full & mask;
                carry  = (a >= b + borrow);
            end
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic waitReady(input string tag);
        int cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!req_ready) checkOutput({tag, ".ready_timeout"}, 32'(req_ready), 32'd1);
    endtask

    // One complete transaction with res_ready high; checks drive in EXEC and result in HOLD.
    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [N-1:0] a,
                                 input logic [N-1:0] b, input logic [1:0] expF,
                                 input logic [N-1:0] expD, input logic expC);
        logic [N-1:0] expB;
        logic         expCin;
        expB   = (op == 3'd5 || op == 3'd6) ? ~b : (op == 3'd7) ? '0 : b;
        expCin = (op == 3'd5 || op == 3'd7) ? 1'b1 :
                 (op == 3'd4) ? (CHAIN ? flag : 1'b0) :
                 (op == 3'd6) ? (CHAIN ? flag : 1'b1) : 1'b0;
        waitReady(tag);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = ~a;
        req_b     = ~b;
        @(negedge clk);
        checkOutput({tag, ".alu_f"}, 32'(alu_f), 32'(expF));
        checkOutput({tag, ".alu_a"}, 32'(alu_a), 32'(a));
        checkOutput({tag, ".alu_b"}, 32'(alu_b), 32'(expB));
        checkOutput({tag, ".alu_c_in"}, 32'(alu_c_in), 32'(expCin));
        checkOutput({tag, ".exec_res_valid"}, 32'(res_valid), 32'd0);
        @(negedge clk);
        checkOutput({tag, ".res_valid"}, 32'(res_valid), 32'd1);
        checkOutput({tag, ".res_data"}, 32'(res_data), 32'(expD));
        checkOutput({tag, ".res_carry"}, 32'(res_carry), 32'(expC));
        if (op >= 3'd3) flag = expC;
    endtask

    initial begin
        int           d;
        bit           c;
        logic [2:0]   rop;
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        vecs[0] = '{3'd3, 8'h7F, 8'h01, 2'b11, 8'h80, 1'b0};
        vecs[1] = '{3'd3, 8'hFF, 8'h01, 2'b11, 8'h00, 1'b1};
        vecs[2] = '{3'd4, 8'h00, 8'h00, 2'b11, CHAIN ? 8'h01 : 8'h00, 1'b0};
        vecs[3] = '{3'd5, 8'h05, 8'h07, 2'b11, 8'hFE, 1'b0};
        vecs[4] = '{3'd6, 8'h10, 8'h00, 2'b11, CHAIN ? 8'h0F : 8'h10, 1'b1};
        vecs[5] = '{3'd0, 8'hF0, 8'h3C, 2'b00, 8'h30, CHAIN};
        vecs[6] = '{3'd1, 8'hF0, 8'h3C, 2'b01, 8'hFC, CHAIN};
        vecs[7] = '{3'd2, 8'hF0, 8'h3C, 2'b10, 8'hC3, CHAIN};
        vecs[8] = '{3'd7, 8'hFF, 8'h55, 2'b11, 8'h00, 1'b1};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset.req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset.res_valid", 32'(res_valid), 32'd0);
        checkOutput("reset.alu_f", 32'(alu_f), 32'd0);
        checkOutput("reset.alu_a", 32'(alu_a), 32'd0);
        checkOutput("reset.res_data", 32'(res_data), 32'd0);
        checkOutput("reset.res_carry", 32'(res_carry), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset.req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 9; i++)
            applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                          vecs[i].f, vecs[i].d, vecs[i].c);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = N'($urandom);
            rb  = N'($urandom);
            refModel(int'(rop), int'(ra), int'(rb), flag, d, c);
            applyStimulus($sformatf("rand%0d", i), rop, ra, rb,
                          (rop < 3'd3) ? rop[1:0] : 2'b11, N'(d), c);
        end

        // Back-pressure: result held for 5 cycles while a second request waits.
        waitReady("hold");
        res_ready = 1'b0;
        req_op    = 3'd3;
        req_a     = 8'h12;
        req_b     = 8'h34;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        req_op    = 3'd1;
        req_a     = 8'hFF;
        req_b     = 8'h00;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("hold%0d.res_valid", i), 32'(res_valid), 32'd1);
            checkOutput($sformatf("hold%0d.res_data", i), 32'(res_data), 32'h46);
            checkOutput($sformatf("hold%0d.req_ready", i), 32'(req_ready), 32'd0);
            req_valid = 1'b1;
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        checkOutput("drain.req_ready", 32'(req_ready), 32'd1);
        checkOutput("drain.res_valid", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("second.alu_f", 32'(alu_f), 32'd1);
        @(negedge clk);
        checkOutput("second.res_valid", 32'(res_valid), 32'd1);
        checkOutput("second.res_data", 32'(res_data), 32'hFF);
        checkOutput("second.res_carry", 32'(res_carry), 32'd0);
        flag = 1'b0;

        // Reset in EXEC discards the operation and clears the carry flag.
        applyStimulus("presetup", 3'd3, 8'hFF, 8'h01, 2'b11, 8'h00, 1'b1);
        waitReady("rst_exec");
        req_op    = 3'd4;
        req_a     = 8'h00;
        req_b     = 8'h00;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_exec.res_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_exec.req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_exec.alu_f", 32'(alu_f), 32'd0);
        checkOutput("rst_exec.alu_a", 32'(alu_a), 32'd0);
        checkOutput("rst_exec.alu_b", 32'(alu_b), 32'd0);
        checkOutput("rst_exec.alu_c_in", 32'(alu_c_in), 32'd0);
        checkOutput("rst_exec.res_data", 32'(res_data), 32'd0);
        checkOutput("rst_exec.res_carry", 32'(res_carry), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_exec.ready_after", 32'(req_ready), 32'd1);
        checkOutput("rst_exec.valid_after", 32'(res_valid), 32'd0);
        flag = 1'b0;
        applyStimulus("post_rst_adc", 3'd4, 8'h00, 8'h00, 2'b11, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
